// File: rtl/pla_sweep_ctrl_if.sv
// rtl/pla_sweep_ctrl_if.sv - function-under-test drive and result stream bundle for pla_sweep_ctrl
interface pla_sweep_ctrl_if #(
  parameter int N_IN = 7
);
  logic [N_IN-1:0] fn_x;
  logic            fn_y;
  logic            out_valid;
  logic            out_ready;
  logic [N_IN-1:0] out_idx;
  logic            out_bit;

  modport master (
    output fn_x, out_valid, out_idx, out_bit,
    input  fn_y, out_ready
  );

  modport slave (
    input  fn_x, out_valid, out_idx, out_bit,
    output fn_y, out_ready
  );
endinterface

// File: rtl/pla_sweep_ctrl.sv
// rtl/pla_sweep_ctrl.sv - exhaustive truth-table sweep of a single-output function with onset count
module pla_sweep_ctrl #(
  parameter int N_IN   = 7,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   onset_cnt,
  pla_sweep_ctrl_if.master sw
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_X   = {N_IN{1'b1}};

  logic [1:0] state;
  logic [3:0] settle_cnt;
  logic       hs;

  assign hs   = sw.out_valid & sw.out_ready;
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      settle_cnt    <= '0;
      sw.fn_x       <= '0;
      sw.out_idx    <= '0;
      sw.out_bit    <= 1'b0;
      sw.out_valid  <= 1'b0;
      onset_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sw.fn_x    <= '0;
            onset_cnt  <= '0;
            settle_cnt <= SETTLE_L;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            sw.fn_x    <= '0;
            settle_cnt <= '0;
            state      <= S_IDLE;
          end else if (settle_cnt <= 4'd1) begin
            // Sampling here lands exactly SETTLE edges after fn_x last moved.
            sw.out_bit   <= sw.fn_y;
            sw.out_idx   <= sw.fn_x;
            sw.out_valid <= 1'b1;
            settle_cnt   <= '0;
            state        <= S_EMIT;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_EMIT: begin
          if (hs) begin
            onset_cnt <= onset_cnt + {{N_IN{1'b0}}, sw.out_bit};
          end
          if (abort) begin
            sw.out_valid <= 1'b0;
            sw.fn_x      <= '0;
            state        <= S_IDLE;
          end else if (hs) begin
            sw.out_valid <= 1'b0;
            // Terminal test precedes the increment so fn_x never wraps.
            if (sw.fn_x == LAST_X) begin
              state <= S_DONE;
            end else begin
              sw.fn_x    <= sw.fn_x + 1'b1;
              settle_cnt <= SETTLE_L;
              state      <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          if (abort) begin
            sw.fn_x <= '0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// tb/tb_pla_sweep_ctrl.sv - directed scoreboard bench for pla_sweep_ctrl
module tb_pla_sweep_ctrl;
  localparam int N = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, abort = 1'b0;
  logic busy0, busy1, done0, done1;
  logic [N:0] onset0, onset1;
  logic ready = 1'b1, rdy_lvl = 1'b1, rand_rdy = 1'b0;
  logic sel = 1'b0, probe = 1'b0;
  int   mode = 0;
  int   total = 0, bad = 0, mism = 0, exp_ones = 0;
  time  st_t;
  logic [1:0] dly0 = 2'b00, dly1 = 2'b00;
  logic [N:0] exp_q[$];
  logic [N:0] e;
  logic stall_prev = 1'b0;
  logic [N-1:0] st_idx = '0;
  logic st_bit = 1'b0;

  pla_sweep_ctrl_if #(.N_IN(N)) i0 ();
  pla_sweep_ctrl_if #(.N_IN(N)) i1 ();

  pla_sweep_ctrl #(.N_IN(N), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .busy(busy0), .done(done0), .onset_cnt(onset0), .sw(i0.master));

  pla_sweep_ctrl #(.N_IN(N), .SETTLE(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .busy(busy1), .done(done1), .onset_cnt(onset1), .sw(i1.master));

  always #5 clk = ~clk;

  function automatic logic fsel(input int md, input logic [N-1:0] x, input logic d);
    case (md)
      0: return 1'b1;
      1: return x[0];
      2: return x[6];
      3: return x[1] ^ x[2];
      default: return d;
    endcase
  endfunction

  function automatic logic exp_bit(input int md, input logic [N-1:0] idx);
    case (md)
      0: return 1'b1;
      2: return idx[6];
      3: return idx[1] ^ idx[2];
      default: return idx[0];
    endcase
  endfunction

  // External function models; mode 4 is fn_x[0] through a two-register delay.
  always @(posedge clk) begin
    dly0 <= {dly0[0], i0.fn_x[0]};
    dly1 <= {dly1[0], i1.fn_x[0]};
  end
  assign i0.fn_y = fsel(mode, i0.fn_x, dly0[1]);
  assign i1.fn_y = fsel(mode, i1.fn_x, dly1[1]);
  assign i0.out_ready = ready;
  assign i1.out_ready = ready;

  wire         m_valid = sel ? i1.out_valid : i0.out_valid;
  wire [N-1:0] m_idx   = sel ? i1.out_idx   : i0.out_idx;
  wire         m_bit   = sel ? i1.out_bit   : i0.out_bit;
  wire [N-1:0] m_fnx   = sel ? i1.fn_x      : i0.fn_x;
  wire         m_busy  = sel ? busy1        : busy0;
  wire         m_done  = sel ? done1        : done0;
  wire [N:0]   m_onset = sel ? onset1       : onset0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      ready = rand_rdy ? ($urandom_range(0, 9) < 3) : rdy_lvl;
    end
  end

  always @(negedge clk) begin
    if (rst_n && m_valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (probe) begin
          if ({m_idx, m_bit} !== e) mism++;
        end else begin
          chk("out_idx", m_idx, e[N:1]);
          chk("out_bit", m_bit, e[0]);
        end
      end
    end
    if (stall_prev && rst_n) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_idx", m_idx, st_idx);
      chk("stall_bit", m_bit, st_bit);
    end
    stall_prev <= rst_n && m_valid && !ready && !abort;
    st_idx     <= m_idx;
    st_bit     <= m_bit;
  end

  task automatic begin_sweep(input logic s, input int md, input logic with_abort);
    logic b;
    sel = s;
    mode = md;
    exp_ones = 0;
    exp_q.delete();
    for (int i = 0; i < (1 << N); i++) begin
      b = exp_bit(md, i[N-1:0]);
      exp_q.push_back({i[N-1:0], b});
      exp_ones += int'(b);
    end
    if (s) start1 = 1'b1; else start0 = 1'b1;
    abort = with_abort;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    abort  = 1'b0;
    st_t   = $time;
    chk("busy_after_start", m_busy, 1);
  endtask

  task automatic finish_sweep(input int exp_cyc, input logic chk_onset);
    int n = 0;
    while (!m_done && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_seen", m_done, 1);
    if (exp_cyc > 0) chk("done_cycle", 32'(($time - st_t) / 10), exp_cyc);
    if (chk_onset) chk("onset_final", m_onset, exp_ones);
    chk("queue_drained", exp_q.size(), 0);
    chk("fn_x_all_ones", m_fnx, (1 << N) - 1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", m_done, 0);
    chk("idle_after_done", m_busy, 0);
    if (chk_onset) chk("onset_held", m_onset, exp_ones);
  endtask

  task automatic wait_fnx(input int v);
    int n = 0;
    while (m_fnx != v[N-1:0] && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_fn_x", m_fnx, v);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_onset", onset0, 0);
    chk("rst_fn_x", i0.fn_x, 0);
    chk("rst_valid", i0.out_valid, 0);
    chk("rst_idx", i0.out_idx, 0);
    chk("rst_bit", i0.out_bit, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Constant function, start coincident with abort in IDLE
    begin_sweep(1'b0, 0, 1'b1);
    finish_sweep(256, 1'b1);
    begin_sweep(1'b0, 1, 1'b0);
    finish_sweep(256, 1'b1);
    begin_sweep(1'b0, 2, 1'b0);
    finish_sweep(256, 1'b1);

    // SETTLE=3 against delayed function
    begin_sweep(1'b1, 4, 1'b0);
    finish_sweep(512, 1'b1);

    // SETTLE=1 against the same delay must sample stale values
    probe = 1'b1;
    mism = 0;
    begin_sweep(1'b0, 4, 1'b0);
    finish_sweep(256, 1'b0);
    chk("settle1_mismatch_seen", 32'(mism > 0), 1);
    probe = 1'b0;

    // Backpressure
    rand_rdy = 1'b1;
    begin_sweep(1'b0, 3, 1'b0);
    finish_sweep(0, 1'b1);
    rand_rdy = 1'b0;
    rdy_lvl = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Abort during EMIT of idx 40 with out_ready low
    begin_sweep(1'b0, 1, 1'b0);
    wait_fnx(40);
    rdy_lvl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pre_valid", m_valid, 1);
    chk("abort_pre_idx", m_idx, 40);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", m_busy, 0);
    chk("abort_valid", m_valid, 0);
    chk("abort_fn_x", m_fnx, 0);
    chk("abort_done", m_done, 0);
    chk("abort_onset", m_onset, 20);
    exp_q.delete();
    rdy_lvl = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_no_done", m_done, 0);
    begin_sweep(1'b0, 3, 1'b0);
    finish_sweep(256, 1'b1);

    // Asynchronous reset mid-sweep
    begin_sweep(1'b0, 2, 1'b0);
    wait_fnx(90);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", m_busy, 0);
    chk("mrst_valid", m_valid, 0);
    chk("mrst_fn_x", m_fnx, 0);
    chk("mrst_onset", m_onset, 0);
    chk("mrst_idx", m_idx, 0);
    chk("mrst_done", m_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_no_resume_busy", m_busy, 0);
    chk("mrst_no_resume_valid", m_valid, 0);

    // Start while busy is ignored
    begin_sweep(1'b0, 0, 1'b0);
    wait_fnx(10);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    chk("busy_start_fn_x", m_fnx, 10);
    chk("busy_start_busy", m_busy, 1);
    finish_sweep(256, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
